// File: rtl/img_pkg.sv
// Image-pipeline constants shared by the window generator and the convolution stage.
package img_pkg;

  localparam int PIXEL_W    = 4;
  localparam int KERNEL_DIM = 3;
  localparam int WINDOW_W   = KERNEL_DIM * KERNEL_DIM * PIXEL_W;

  // Bit offset of window slot k (k = 3*row + col) inside the packed window word.
  function automatic int slot_offset(input int k, input int pw = PIXEL_W);
    return k * pw;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: synchronous write, same-cycle read of the old contents.
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; stale words are masked downstream by valid gating.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

  // Read is combinational, so during a write cycle dout still shows the previous line's pixel.
  assign dout = mem[addr];

endmodule

// File: rtl/window_generator_3x3.sv
// Turns a raster pixel stream into registered 3x3 neighbourhoods for the convolution stage.
module window_generator_3x3
  import img_pkg::*;
#(
  parameter int PIXEL_W    = img_pkg::PIXEL_W,
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [PIXEL_W-1:0]                      i_pixel,
  input  logic                                    i_pixel_valid,
  input  logic                                    i_sof,
  output logic [KERNEL_DIM*KERNEL_DIM*PIXEL_W-1:0] o_pixels,
  output logic                                    o_valid,
  output logic                                    o_frame_done
);

  localparam int NSLOT = KERNEL_DIM * KERNEL_DIM;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]      col_cnt, eff_col;
  logic [RW-1:0]      row_cnt, eff_row;
  logic [PIXEL_W-1:0] mid_q, top_q;
  logic [PIXEL_W-1:0] win [NSLOT];

  // Start-of-frame forces position (0,0) regardless of where the counters are.
  always_comb begin
    eff_col = i_sof ? '0 : col_cnt;
    eff_row = i_sof ? '0 : row_cnt;
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb_mid (
    .clk  (clk),
    .en   (i_pixel_valid),
    .addr (eff_col),
    .din  (i_pixel),
    .dout (mid_q)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb_top (
    .clk  (clk),
    .en   (i_pixel_valid),
    .addr (eff_col),
    .din  (mid_q),
    .dout (top_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      for (int k = 0; k < NSLOT; k++) win[k] <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_pixel_valid) begin
        // NOTE: non-blocking assignments let every column read its neighbour's pre-shift value.
        for (int r = 0; r < KERNEL_DIM; r++) begin
          for (int c = 0; c < KERNEL_DIM - 1; c++) begin
            win[r*KERNEL_DIM + c] <= win[r*KERNEL_DIM + c + 1];
          end
        end
        win[KERNEL_DIM-1]     <= top_q;
        win[2*KERNEL_DIM-1]   <= mid_q;
        win[3*KERNEL_DIM-1]   <= i_pixel;

        // Column gating keeps windows from straddling end and start of adjacent lines.
        o_valid <= (eff_row >= RW'(2)) && (eff_col >= CW'(2));

        if (eff_col == COL_LAST) begin
          col_cnt <= '0;
          if (eff_row == ROW_LAST) begin
            row_cnt      <= '0;
            o_frame_done <= 1'b1;
          end else begin
            row_cnt <= eff_row + 1'b1;
          end
        end else begin
          col_cnt <= eff_col + 1'b1;
          row_cnt <= eff_row;
        end
      end
    end
  end

  always_comb begin
    o_pixels = '0;
    for (int k = 0; k < NSLOT; k++) begin
      o_pixels[slot_offset(k, PIXEL_W) +: PIXEL_W] = win[k];
    end
  end

endmodule

// File: tb/tb_window_generator_3x3.sv
// Scoreboard bench for window_generator_3x3 on a 4x4 frame with hand-computed windows.
module tb_window_generator_3x3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_pixel;
  logic        i_pixel_valid;
  logic        i_sof;
  logic [35:0] o_pixels;
  logic        o_valid;
  logic        o_frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [35:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          done_q[$];
  logic [35:0] cur_w [4];

  window_generator_3x3 #(.PIXEL_W(4), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pixel       (i_pixel),
    .i_pixel_valid (i_pixel_valid),
    .i_sof         (i_sof),
    .o_pixels      (o_pixels),
    .o_valid       (o_valid),
    .o_frame_done  (o_frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations, mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("window_valid", 64'(o_valid), 64'd1);
        check("window_pixels", 64'(o_pixels), 64'(e.word));
      end else if (o_valid) begin
        check("spurious_valid", 64'(o_valid), 64'd0);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        check("frame_done", 64'(o_frame_done), 64'd1);
      end else if (o_frame_done) begin
        check("spurious_frame_done", 64'(o_frame_done), 64'd0);
      end
    end
  end

  task automatic send(input logic [3:0] p, input logic sof, input bit has_win,
                      input logic [35:0] w, input bit done);
    exp_t e;
    @(posedge clk); #1;
    i_pixel       = p;
    i_pixel_valid = 1'b1;
    i_sof         = sof;
    if (has_win) begin
      e.cyc  = cyc + 1;
      e.word = w;
      exp_q.push_back(e);
    end
    if (done) done_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_pixel_valid = 1'b0;
      i_sof         = 1'b0;
    end
  endtask

  // One 4x4 frame; windows expected at (2,2),(2,3),(3,2),(3,3) come from cur_w.
  task automatic run_frame(input bit is_const, input logic [3:0] cval, input int start,
                           input bit sof_first, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      int          r, c;
      logic [3:0]  v;
      bit          hw;
      r  = i / 4;
      c  = i % 4;
      v  = is_const ? cval : 4'(start + i);
      hw = (r >= 2) && (c >= 2);
      if (gaps && i > 0) idle(int'($urandom_range(3, 1)));
      send(v, sof_first && (i == 0), hw, hw ? cur_w[(r-2)*2 + (c-2)] : 36'h0, i == 15);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; i_pixel = '0; i_pixel_valid = 1'b0; i_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_done", 64'(o_frame_done), 64'd0);
    check("reset_pixels", 64'(o_pixels), 64'd0);
    reset = 1'b1;
    idle(2);

    // Continuous frame, pixel n = n.
    cur_w = '{36'hA98654210, 36'hBA9765321, 36'hEDCA98654, 36'hFEDBA9765};
    run_frame(1'b0, 4'h0, 0, 1'b1, 1'b0);
    idle(2);

    // All-ones frame.
    cur_w = '{36'h111111111, 36'h111111111, 36'h111111111, 36'h111111111};
    run_frame(1'b1, 4'h1, 0, 1'b1, 1'b0);
    idle(2);

    // Same frame as the first, with 1-3 idle cycles between pixels.
    cur_w = '{36'hA98654210, 36'hBA9765321, 36'hEDCA98654, 36'hFEDBA9765};
    run_frame(1'b0, 4'h0, 0, 1'b1, 1'b1);
    idle(2);

    // Start-of-frame on pixel 6 mid-frame: that pixel becomes (0,0).
    for (int i = 0; i < 6; i++) send(4'(i), i == 0, 1'b0, 36'h0, 1'b0);
    cur_w = '{36'h0FECBA876, 36'h10FDCB987, 36'h4320FECBA, 36'h54310FDCB};
    run_frame(1'b0, 4'h0, 6, 1'b1, 1'b0);
    idle(2);

    // Reset after pixel 9, then continue from pixel 10 without start-of-frame.
    for (int i = 0; i < 10; i++) send(4'(i), i == 0, 1'b0, 36'h0, 1'b0);
    idle(1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset_valid", 64'(o_valid), 64'd0);
    check("midreset_done", 64'(o_frame_done), 64'd0);
    check("midreset_pixels", 64'(o_pixels), 64'd0);
    cur_w = '{36'h4320FECBA, 36'h54310FDCB, 36'h8764320FE, 36'h98754310F};
    run_frame(1'b0, 4'h0, 10, 1'b0, 1'b0);
    idle(2);

    // Back-to-back frames: all-F frame immediately followed by the counting frame.
    cur_w = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF};
    run_frame(1'b1, 4'hF, 0, 1'b1, 1'b0);
    cur_w = '{36'hA98654210, 36'hBA9765321, 36'hEDCA98654, 36'hFEDBA9765};
    run_frame(1'b0, 4'h0, 0, 1'b1, 1'b0);
    idle(5);

    check("windows_outstanding", 64'(exp_q.size()), 64'd0);
    check("frame_done_outstanding", 64'(done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
